// File: rtl/capture_trig_ctrl.sv
// Acquisition controller for the circular sample RAM.
// Fills the pre-trigger region, waits for one trigger edge, then records the post-trigger samples.
module capture_trig_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_en,
  input  logic              run,
  input  logic              clr_done,
  input  logic [1:0]        trig_src,
  input  logic              SPItrig,
  input  logic              UARTtrig,
  input  logic              CHtrig,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done
);

  localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARM,
    S_POST,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] taddr_q, taddr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic              trig_q, trig_d;
  logic              done_q, done_d;
  logic              src_q;

  logic              sel;
  logic              hit;
  logic              active;
  logic              we_i;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   pre_thr;
  logic [ADDR_W:0]   post_thr;
  logic [ADDR_W-1:0] waddr_inc;

  always_comb begin
    sel = 1'b0;
    unique case (trig_src)
      2'b00: sel = SPItrig;
      2'b01: sel = UARTtrig;
      2'b10: sel = CHtrig;
      2'b11: sel = force_trig;
      default: sel = 1'b0;
    endcase
  end

  // Rising edge only: a level already high when arming never fires.
  assign hit = sel & ~src_q;

  assign active = (state_q == S_PRE) ||
                  (state_q == S_ARM) ||
                  (state_q == S_POST);

  assign we_i      = smpl_en & active;
  assign cnt_inc   = cnt_q + CNT_ONE;
  assign waddr_inc = waddr_q + ADR_ONE;
  assign pre_thr   = DEPTH_C - {1'b0, trig_pos};
  assign post_thr  = {1'b0, trig_pos};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    trig_d  = trig_q;
    done_d  = done_q;
    taddr_d = taddr_q;
    waddr_d = we_i ? waddr_inc : waddr_q;

    if (run) begin
      // Restart from any state; an in-flight write still lands.
      state_d = S_PRE;
      cnt_d   = '0;
      armed_d = 1'b0;
      trig_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_PRE: begin
          if (we_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pre_thr) begin
              state_d = S_ARM;
              armed_d = 1'b1;
            end
          end
        end
        S_ARM: begin
          if (hit) begin
            trig_d  = 1'b1;
            armed_d = 1'b0;
            cnt_d   = '0;
            taddr_d = waddr_d;
            if (trig_pos == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_POST;
            end
          end
        end
        S_POST: begin
          if (we_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == post_thr) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (clr_done) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      taddr_q <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      taddr_q <= taddr_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      src_q   <= sel;
    end
  end

  assign we           = we_i;
  assign waddr        = waddr_q;
  assign trig_addr    = taddr_q;
  assign armed        = armed_q;
  assign triggered    = trig_q;
  assign capture_done = done_q;

endmodule

// File: tb/tb_capture_trig_ctrl.sv
// Directed bench for capture_trig_ctrl at ADDR_W=4.
// Expected values are hand-computed from the acquisition sequence.
module tb_capture_trig_ctrl;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          smpl_en;
  logic          run;
  logic          clr_done;
  logic [1:0]    trig_src;
  logic          SPItrig;
  logic          UARTtrig;
  logic          CHtrig;
  logic          force_trig;
  logic [AW-1:0] trig_pos;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] trig_addr;
  logic          armed;
  logic          triggered;
  logic          capture_done;

  int n_tests = 0;
  int n_fail  = 0;

  capture_trig_ctrl #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .smpl_en      (smpl_en),
    .run          (run),
    .clr_done     (clr_done),
    .trig_src     (trig_src),
    .SPItrig      (SPItrig),
    .UARTtrig     (UARTtrig),
    .CHtrig       (CHtrig),
    .force_trig   (force_trig),
    .trig_pos     (trig_pos),
    .we           (we),
    .waddr        (waddr),
    .trig_addr    (trig_addr),
    .armed        (armed),
    .triggered    (triggered),
    .capture_done (capture_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int n);
    repeat (n) begin
      smpl_en = 1'b1;
      tick();
      smpl_en = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_done = 1'b1;
    tick();
    clr_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; smpl_en = 1'b0; run = 1'b0; clr_done = 1'b0;
    trig_src = 2'b00; SPItrig = 1'b0; UARTtrig = 1'b0;
    CHtrig = 1'b0; force_trig = 1'b0; trig_pos = 4'd4;
    repeat (2) tick();
    n_tests++;
    if ({we, waddr, trig_addr, armed, triggered, capture_done} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 000",
               {we, waddr, trig_addr, armed, triggered, capture_done});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    trig_pos = 4'd4; trig_src = 2'b00;
    pulse_run();
    smp(11);
    n_tests++;
    if (armed !== 1'b0) begin
      n_fail++; $display("FAIL armed_early: got %b want 0", armed);
    end
    smp(1);
    n_tests++;
    if (armed !== 1'b1 || waddr !== 4'd12) begin
      n_fail++;
      $display("FAIL armed_12th: got armed=%b waddr=%0d want 1/12", armed, waddr);
    end
    SPItrig = 1'b1; tick(); SPItrig = 1'b0; tick();
    n_tests++;
    if (triggered !== 1'b1 || armed !== 1'b0 || trig_addr !== 4'd12) begin
      n_fail++;
      $display("FAIL spi_trig: got trg=%b arm=%b ta=%0d want 1/0/12",
               triggered, armed, trig_addr);
    end
    smp(3);
    n_tests++;
    if (capture_done !== 1'b0) begin
      n_fail++; $display("FAIL done_early: got %b want 0", capture_done);
    end
    smp(1);
    n_tests++;
    if (capture_done !== 1'b1 || waddr !== 4'd0) begin
      n_fail++;
      $display("FAIL done_4: got done=%b waddr=%0d want 1/0", capture_done, waddr);
    end
    pulse_clr();
    n_tests++;
    if (capture_done !== 1'b0 || triggered !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_done: got done=%b trg=%b want 0/1", capture_done, triggered);
    end
  endtask

  task automatic test_held_level();
    SPItrig = 1'b1;
    repeat (2) tick();
    pulse_run();
    n_tests++;
    if (triggered !== 1'b0) begin
      n_fail++; $display("FAIL run_clears_trg: got %b want 0", triggered);
    end
    smp(12);
    repeat (3) tick();
    n_tests++;
    if (armed !== 1'b1 || triggered !== 1'b0) begin
      n_fail++;
      $display("FAIL held_level: got arm=%b trg=%b want 1/0", armed, triggered);
    end
    SPItrig = 1'b0; tick(); SPItrig = 1'b1; tick(); SPItrig = 1'b0;
    n_tests++;
    if (triggered !== 1'b1 || trig_addr !== 4'd12) begin
      n_fail++;
      $display("FAIL reraise: got trg=%b ta=%0d want 1/12", triggered, trig_addr);
    end
    smp(4);
    pulse_clr();
  endtask

  task automatic test_src_select();
    trig_src = 2'b01;
    pulse_run();
    smp(12);
    SPItrig = 1'b1; CHtrig = 1'b1; tick();
    SPItrig = 1'b0; CHtrig = 1'b0; tick();
    n_tests++;
    if (triggered !== 1'b0 || armed !== 1'b1) begin
      n_fail++;
      $display("FAIL other_src: got trg=%b arm=%b want 0/1", triggered, armed);
    end
    UARTtrig = 1'b1; tick(); UARTtrig = 1'b0; tick();
    n_tests++;
    if (triggered !== 1'b1 || trig_addr !== 4'd12) begin
      n_fail++;
      $display("FAIL uart_trig: got trg=%b ta=%0d want 1/12", triggered, trig_addr);
    end
    smp(4);
    n_tests++;
    if (capture_done !== 1'b1 || waddr !== 4'd0) begin
      n_fail++;
      $display("FAIL uart_done: got done=%b waddr=%0d want 1/0", capture_done, waddr);
    end
    pulse_clr();
  endtask

  task automatic test_zero_pos();
    trig_pos = 4'd0; trig_src = 2'b11;
    pulse_run();
    smp(15);
    n_tests++;
    if (armed !== 1'b0) begin
      n_fail++; $display("FAIL zero_pos_early: got %b want 0", armed);
    end
    smp(1);
    n_tests++;
    if (armed !== 1'b1) begin
      n_fail++; $display("FAIL zero_pos_arm: got %b want 1", armed);
    end
    force_trig = 1'b1; tick(); force_trig = 1'b0;
    n_tests++;
    if (capture_done !== 1'b1 || triggered !== 1'b1 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pos_done: got done=%b trg=%b arm=%b want 1/1/0",
               capture_done, triggered, armed);
    end
    smpl_en = 1'b1;
    #1;
    n_tests++;
    if (we !== 1'b0) begin
      n_fail++; $display("FAIL we_in_done: got %b want 0", we);
    end
    tick();
    smpl_en = 1'b0;
    tick();
    n_tests++;
    if (waddr !== 4'd0) begin
      n_fail++; $display("FAIL waddr_frozen: got %0d want 0", waddr);
    end
    pulse_clr();
  endtask

  task automatic test_wrap();
    pulse_run();
    smp(14);
    trig_pos = 4'd15;
    pulse_run();
    smp(1);
    n_tests++;
    if (armed !== 1'b1 || waddr !== 4'd15) begin
      n_fail++;
      $display("FAIL wrap_arm: got arm=%b waddr=%0d want 1/15", armed, waddr);
    end
    force_trig = 1'b1; smpl_en = 1'b1; tick();
    force_trig = 1'b0; smpl_en = 1'b0; tick();
    n_tests++;
    if (triggered !== 1'b1 || trig_addr !== 4'd0 || waddr !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_trig: got trg=%b ta=%0d wa=%0d want 1/0/0",
               triggered, trig_addr, waddr);
    end
    smp(14);
    n_tests++;
    if (capture_done !== 1'b0) begin
      n_fail++; $display("FAIL wrap_done_early: got %b want 0", capture_done);
    end
    smp(1);
    n_tests++;
    if (capture_done !== 1'b1 || waddr !== 4'd15) begin
      n_fail++;
      $display("FAIL wrap_done: got done=%b waddr=%0d want 1/15", capture_done, waddr);
    end
    pulse_clr();
  endtask

  task automatic test_restart();
    trig_pos = 4'd4;
    pulse_run();
    smp(12);
    force_trig = 1'b1; tick(); force_trig = 1'b0; tick();
    smp(2);
    run = 1'b1; smpl_en = 1'b1; tick();
    run = 1'b0; smpl_en = 1'b0; tick();
    n_tests++;
    if (armed !== 1'b0 || triggered !== 1'b0 || waddr !== 4'd14) begin
      n_fail++;
      $display("FAIL run_mid_post: got arm=%b trg=%b wa=%0d want 0/0/14",
               armed, triggered, waddr);
    end
    smp(11);
    n_tests++;
    if (armed !== 1'b0) begin
      n_fail++; $display("FAIL restart_early: got %b want 0", armed);
    end
    smp(1);
    n_tests++;
    if (armed !== 1'b1 || waddr !== 4'd10) begin
      n_fail++;
      $display("FAIL restart_arm: got arm=%b wa=%0d want 1/10", armed, waddr);
    end
    force_trig = 1'b1; tick(); force_trig = 1'b0; tick();
    smp(4);
    n_tests++;
    if (capture_done !== 1'b1 || trig_addr !== 4'd10 || waddr !== 4'd14) begin
      n_fail++;
      $display("FAIL restart_done: got done=%b ta=%0d wa=%0d want 1/10/14",
               capture_done, trig_addr, waddr);
    end
    run = 1'b1; clr_done = 1'b1; tick();
    run = 1'b0; clr_done = 1'b0;
    smp(1);
    n_tests++;
    if (capture_done !== 1'b0 || triggered !== 1'b0 || waddr !== 4'd15) begin
      n_fail++;
      $display("FAIL run_wins: got done=%b trg=%b wa=%0d want 0/0/15",
               capture_done, triggered, waddr);
    end
    smpl_en = 1'b1;
    #2;
    n_tests++;
    if (we !== 1'b1) begin
      n_fail++; $display("FAIL we_in_pre: got %b want 1", we);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({we, waddr, trig_addr, armed, triggered, capture_done} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 000",
               {we, waddr, trig_addr, armed, triggered, capture_done});
    end
    smpl_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_level();
    test_src_select();
    test_zero_pos();
    test_wrap();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
